id_ex_stage: RTL

- ID/EX pipeline register plus operand-forwarding logic for the 5-stage RV32I core.
- Captures decoded operands and control from ID, then drives the EX-stage ALU operands (A, B, 4-bit ALUControl) and the store data.
- Resolves RAW hazards by forwarding from MEM/WB, and flags load-use hazards to the hazard unit.
- Honours stall (hold) and flush (bubble) from the hazard/branch logic.

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/id_ex_stage_fwd_mux.sv | 44 ++++
 rtl/id_ex_stage.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I pipeline: ALU op encodings, ID/EX control bundle, forward selects.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_SLL  = 4'b1010,
    ALU_SRL  = 4'b1011,
    ALU_SRA  = 4'b1100,
    ALU_NOR  = 4'b1101
  } alu_op_e;

  typedef struct packed {
    logic [3:0] alu_control;
    logic       alu_src;
    logic       alu_a_pc;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
  } id_ex_ctrl_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Forwarding select and data mux for one EX source operand; MEM beats WB, x0 is never forwarded.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs,
  input  logic [DW-1:0] reg_data,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] data
);

  fwd_sel_e sel;

  // Pick the youngest in-flight producer of rs.
  always_comb begin
    sel = FWD_REG;
    if (mem_we && (mem_rd != {AW{1'b0}}) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != {AW{1'b0}}) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
  end

  // Operand data mux driven by the select.
  always_comb begin
    data = reg_data;
    case (sel)
      FWD_MEM: data = mem_data;
      FWD_WB:  data = wb_data;
      FWD_REG: data = reg_data;
      default: data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use detection.
// Optional stall/bubble counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [9:0]      id_ctrl,
  input  logic            mem_fwd_we,
  input  logic [RA_W-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_we,
  input  logic [RA_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd,
  output logic [9:0]      ex_ctrl,
  output logic [XLEN-1:0] ex_alu_a,
  output logic [XLEN-1:0] ex_alu_b,
  output logic [3:0]      ex_alu_control,
  output logic [XLEN-1:0] ex_store_data,
  output logic            load_use_hazard,
  output logic [31:0]     stall_count,
  output logic [31:0]     bubble_count
);

  id_ex_ctrl_t     ctrl;
  logic [RA_W-1:0] ex_rs1;
  logic [RA_W-1:0] ex_rs2;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            bubble;

  // An explicit flush, or an unstalled load of an empty ID slot, inserts a bubble.
  assign bubble = flush || (!stall && !id_valid);

  // Pipeline register: flush > stall > load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_pc       <= {XLEN{1'b0}};
      ex_rd       <= {RA_W{1'b0}};
      ex_rs1      <= {RA_W{1'b0}};
      ex_rs2      <= {RA_W{1'b0}};
      ex_rs1_data <= {XLEN{1'b0}};
      ex_rs2_data <= {XLEN{1'b0}};
      ex_imm      <= {XLEN{1'b0}};
      ctrl        <= '0;
    end else if (bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= {XLEN{1'b0}};
      ex_rd       <= {RA_W{1'b0}};
      ex_rs1      <= {RA_W{1'b0}};
      ex_rs2      <= {RA_W{1'b0}};
      ex_rs1_data <= {XLEN{1'b0}};
      ex_rs2_data <= {XLEN{1'b0}};
      ex_imm      <= {XLEN{1'b0}};
      ctrl        <= '0;
    end else if (stall) begin
      // Capture forwarded values so a producer retiring during the stall is not lost.
      ex_rs1_data <= fwd_rs1;
      ex_rs2_data <= fwd_rs2;
    end else begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_rd       <= id_rd;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ctrl        <= id_ex_ctrl_t'(id_ctrl);
    end
  end

  fwd_mux #(.DW(XLEN), .AW(RA_W)) u_fwd_rs1 (
    .rs       (ex_rs1),
    .reg_data (ex_rs1_data),
    .mem_we   (mem_fwd_we),
    .mem_rd   (mem_fwd_rd),
    .mem_data (mem_fwd_data),
    .wb_we    (wb_fwd_we),
    .wb_rd    (wb_fwd_rd),
    .wb_data  (wb_fwd_data),
    .data     (fwd_rs1)
  );

  fwd_mux #(.DW(XLEN), .AW(RA_W)) u_fwd_rs2 (
    .rs       (ex_rs2),
    .reg_data (ex_rs2_data),
    .mem_we   (mem_fwd_we),
    .mem_rd   (mem_fwd_rd),
    .mem_data (mem_fwd_data),
    .wb_we    (wb_fwd_we),
    .wb_rd    (wb_fwd_rd),
    .wb_data  (wb_fwd_data),
    .data     (fwd_rs2)
  );

  assign ex_ctrl        = ctrl;
  assign ex_alu_control = ctrl.alu_control;
  assign ex_alu_a       = ctrl.alu_a_pc ? ex_pc : fwd_rs1;
  assign ex_alu_b       = ctrl.alu_src ? ex_imm : fwd_rs2;
  assign ex_store_data  = fwd_rs2;

  assign load_use_hazard = ex_valid && ctrl.mem_read && (ex_rd != {RA_W{1'b0}}) && id_valid &&
                           ((ex_rd == id_rs1) || (ex_rd == id_rs2));

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (stall && !flush) begin
        stall_cnt <= stall_cnt + 32'd1;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (bubble) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end else begin
        bubble_cnt <= bubble_cnt;
      end
    end
  end

  assign stall_count  = stall_cnt;
  assign bubble_count = bubble_cnt;
`else
  assign stall_count  = 32'd0;
  assign bubble_count = 32'd0;
`endif

endmodule
